// File: rtl/uart_word_tx.sv
// uart_word_tx: pops 16-bit words and sends HEADER/high/low byte frames.
// Define UART_WORD_TX_CKSUM_EN to append an XOR checksum byte per frame.

module uart_word_tx #(
  parameter logic [7:0] HEADER = 8'h80
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        fifo_empty,
  input  logic [15:0] fifo_dout,
  output logic        fifo_rd_en,
  output logic        transmit,
  output logic [7:0]  tx_byte,
  input  logic        is_transmitting,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_count
);

`ifdef UART_WORD_TX_CKSUM_EN
  localparam logic [1:0] LAST_IDX = 2'd3;
`else
  localparam logic [1:0] LAST_IDX = 2'd2;
`endif

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LATCH,
    SEND,
    GAP,
    DRAIN
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] word;
  logic [15:0] word_nxt;
  logic [1:0]  idx;
  logic [1:0]  idx_nxt;
  logic [7:0]  tx_byte_nxt;
  logic        frame_done_nxt;
  logic [15:0] frame_count_nxt;

  function automatic logic [7:0] byte_at(
    input logic [1:0]  i,
    input logic [15:0] w
  );
    logic [7:0] b;
    case (i)
      2'd0:    b = HEADER;
      2'd1:    b = w[15:8];
      2'd2:    b = w[7:0];
`ifdef UART_WORD_TX_CKSUM_EN
      2'd3:    b = w[15:8] ^ w[7:0];
`endif
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  assign fifo_rd_en = (state == POP);
  assign transmit   = (state == SEND);
  assign busy       = (state != IDLE);

  // State, latched word, byte index and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      word        <= 16'h0000;
      idx         <= 2'd0;
      tx_byte     <= 8'h00;
      frame_done  <= 1'b0;
      frame_count <= 16'h0000;
    end else begin
      state       <= state_nxt;
      word        <= word_nxt;
      idx         <= idx_nxt;
      tx_byte     <= tx_byte_nxt;
      frame_done  <= frame_done_nxt;
      frame_count <= frame_count_nxt;
    end
  end

  // Next-state logic; tx_byte is loaded on the way into SEND.
  always_comb begin
    state_nxt       = state;
    word_nxt        = word;
    idx_nxt         = idx;
    tx_byte_nxt     = tx_byte;
    frame_done_nxt  = 1'b0;
    frame_count_nxt = frame_count;
    unique case (state)
      IDLE: begin
        if (enable && !fifo_empty && !is_transmitting)
          state_nxt = POP;
      end
      POP: begin
        state_nxt = LATCH;
      end
      LATCH: begin
        word_nxt    = fifo_dout;
        idx_nxt     = 2'd0;
        tx_byte_nxt = HEADER;
        state_nxt   = SEND;
      end
      SEND: begin
        state_nxt = GAP;
      end
      GAP: begin
        state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!is_transmitting) begin
          if (idx == LAST_IDX) begin
            frame_done_nxt  = 1'b1;
            frame_count_nxt = frame_count + 16'd1;
            state_nxt       = IDLE;
          end else begin
            idx_nxt     = idx + 2'd1;
            tx_byte_nxt = byte_at(idx + 2'd1, word);
            state_nxt   = SEND;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_word_tx.sv
// tb_uart_word_tx: random and directed stimulus against a cycle-level model.
// Define UART_WORD_TX_CKSUM_EN to test the 4-byte checksum frame.

module tb_uart_word_tx;

  localparam logic [7:0] HDR = 8'h80;
`ifdef UART_WORD_TX_CKSUM_EN
  localparam int NB = 4;
`else
  localparam int NB = 3;
`endif

  localparam logic [7:0] LIT [0:2][0:3] = '{
    '{8'h80, 8'h12, 8'h34, 8'h26},
    '{8'h80, 8'hAB, 8'hCD, 8'h66},
    '{8'h80, 8'h00, 8'hFF, 8'hFF}
  };
  localparam logic [15:0] LIT_CNT [0:3] = '{16'd1, 16'd2, 16'd3, 16'd4};

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        fifo_empty;
  logic [15:0] fifo_dout;
  logic        fifo_rd_en;
  logic        transmit;
  logic [7:0]  tx_byte;
  logic        is_transmitting;
  logic        busy;
  logic        frame_done;
  logic [15:0] frame_count;

  always #5 clk = ~clk;

  uart_word_tx #(.HEADER(HDR)) dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .fifo_empty      (fifo_empty),
    .fifo_dout       (fifo_dout),
    .fifo_rd_en      (fifo_rd_en),
    .transmit        (transmit),
    .tx_byte         (tx_byte),
    .is_transmitting (is_transmitting),
    .busy            (busy),
    .frame_done      (frame_done),
    .frame_count     (frame_count)
  );

  int checks = 0;
  int errors = 0;

  // model state, owned by the compare process
  logic [7:0]  expq[$];
  logic [7:0]  fb[$];
  int          since;
  int          rem;
  int          frame_idx = 0;
  bit          active, waiting, latch_pend, wrap_pend;
  bit          n_rd, n_tx, n_done;
  bit          e_rd, e_tx, e_done, busy_e;
  logic [15:0] cnt;
  logic [15:0] w;
  logic [7:0]  last_byte;
  logic [7:0]  eb;

  // stimulus state, owned by the main process
  logic [15:0] fq[$];
  int          ubusy = 0;
  int          bt_lo = 20;
  int          bt_hi = 20;
  int          tmo = 0;
  int          n_tx_seen = 0;
  int          n_done_seen = 0;
  bit          preset = 1'b0;
  bit          done = 1'b0;

  function void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function void model_reset();
    expq.delete();
    fb.delete();
    since = 0; rem = 0;
    active = 0; waiting = 0; latch_pend = 0; wrap_pend = 0;
    n_rd = 0; n_tx = 0; n_done = 0;
    cnt = 16'h0000;
    last_byte = 8'h00;
  endfunction

  // compare process: predicts every output each cycle from the frame rules
  always @(negedge clk) begin
    if (done) begin
      checks++;
      if (tmo != 0) begin
        errors++;
        $display("FAIL timeout: %0d waits expired, want 0", tmo);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end else if (rst) begin
      chk("rst_rd_en", fifo_rd_en, 0);
      chk("rst_transmit", transmit, 0);
      chk("rst_tx_byte", tx_byte, 0);
      chk("rst_busy", busy, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_frame_count", frame_count, 0);
      model_reset();
    end else begin
      if (preset) begin
        cnt = 16'hFFFF;
        wrap_pend = 1;
      end
      e_rd = n_rd; e_tx = n_tx; e_done = n_done; busy_e = active;
      n_rd = 0; n_tx = 0; n_done = 0;
      if (e_done) cnt = cnt + 16'd1;
      chk("rd_en", fifo_rd_en, e_rd);
      chk("transmit", transmit, e_tx);
      chk("frame_done", frame_done, e_done);
      chk("busy", busy, busy_e);
      chk("frame_count", frame_count, cnt);
      if (fifo_rd_en) chk("pop_when_empty", fifo_empty, 0);
      if (transmit) chk("tx_while_uart_busy", is_transmitting, 0);
      if (e_tx) begin
        eb = (expq.size() > 0) ? expq.pop_front() : last_byte;
        chk("tx_byte", tx_byte, eb);
        last_byte = eb;
        fb.push_back(tx_byte);
      end else begin
        chk("tx_byte_hold", tx_byte, last_byte);
      end
      if (e_done) begin
        if (frame_idx < 3)
          for (int i = 0; i < NB; i++)
            chk($sformatf("lit_f%0d_b%0d", frame_idx, i),
                fb[i], LIT[frame_idx][i]);
        if (frame_idx < 4)
          chk($sformatf("lit_count_f%0d", frame_idx),
              frame_count, LIT_CNT[frame_idx]);
        if (wrap_pend) begin
          chk("wrap_count", frame_count, 16'h0000);
          wrap_pend = 0;
        end
        frame_idx++;
        fb.delete();
      end
      if (latch_pend) begin
        w = fifo_dout;
        expq.push_back(HDR);
        expq.push_back(w[15:8]);
        expq.push_back(w[7:0]);
        if (NB == 4) expq.push_back(w[15:8] ^ w[7:0]);
        rem = NB;
        latch_pend = 0;
        n_tx = 1;
      end
      if (e_rd) latch_pend = 1;
      if (e_tx) begin
        rem--;
        waiting = 1;
        since = 0;
      end else if (waiting) begin
        since++;
        if (since >= 2 && !is_transmitting) begin
          waiting = 0;
          if (rem == 0) begin
            n_done = 1;
            active = 0;
          end else begin
            n_tx = 1;
          end
        end
      end
      if (!busy_e && enable && !fifo_empty && !is_transmitting) begin
        n_rd = 1;
        active = 1;
      end
    end
  end

  // one clock of FIFO and uart behaviour; inputs change 1 after posedge
  task automatic tick();
    bit srd, stx, sfd;
    @(negedge clk);
    srd = fifo_rd_en;
    stx = transmit;
    sfd = frame_done;
    @(posedge clk);
    #1;
    if (srd && fq.size() > 0) fifo_dout = fq.pop_front();
    if (ubusy > 0) ubusy--;
    if (stx) ubusy = int'($urandom_range(bt_hi, bt_lo));
    is_transmitting = (ubusy > 0);
    fifo_empty = (fq.size() == 0);
    if (stx) n_tx_seen++;
    if (sfd) n_done_seen++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push(input logic [15:0] d);
    fq.push_back(d);
    fifo_empty = 1'b0;
  endtask

  task automatic wait_done(input int n, input int lim);
    int tgt = n_done_seen + n;
    int t = 0;
    while (n_done_seen < tgt && t < lim) begin
      tick();
      t++;
    end
    if (n_done_seen < tgt) tmo++;
  endtask

  task automatic wait_tx(input int n, input int lim);
    int tgt = n_tx_seen + n;
    int t = 0;
    while (n_tx_seen < tgt && t < lim) begin
      tick();
      t++;
    end
    if (n_tx_seen < tgt) tmo++;
  endtask

  initial begin
    int t;
    int pushed;
    rst = 1'b0;
    enable = 1'b0;
    fifo_empty = 1'b1;
    fifo_dout = 16'h0000;
    is_transmitting = 1'b0;
    #1 rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(2);

    // single word, 20-cycle uart byte time
    push(16'h1234);
    enable = 1'b1;
    wait_done(1, 300);
    idle(3);

    // two words back to back
    push(16'hABCD);
    push(16'h00FF);
    wait_done(2, 600);
    idle(3);

    // enable dropped during byte 1 with three words queued
    for (int i = 0; i < 3; i++) push(16'($urandom));
    wait_tx(2, 200);
    enable = 1'b0;
    wait_done(1, 300);
    idle(60);
    fq.delete();
    fifo_empty = 1'b1;
    idle(2);

    // reset while draining byte 1
    enable = 1'b1;
    push(16'($urandom));
    wait_tx(2, 200);
    idle(4);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(50);

    // random traffic, enable toggling, short random uart byte times
    bt_lo = 1;
    bt_hi = 8;
    pushed = 0;
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 5) == 0 && pushed < 25) begin
        push(16'($urandom));
        pushed++;
      end
      if ($urandom_range(0, 15) == 0) enable = ~enable;
      tick();
    end
    enable = 1'b1;
    t = 0;
    while ((fq.size() != 0 || busy) && t < 3000) begin
      tick();
      t++;
    end
    if (fq.size() != 0 || busy) tmo++;
    idle(5);

`ifdef UART_WORD_TX_CKSUM_EN
    // frame_count wraps from FFFF to 0000
    bt_lo = 20;
    bt_hi = 20;
    force dut.frame_count = 16'hFFFF;
    preset = 1'b1;
    tick();
    release dut.frame_count;
    preset = 1'b0;
    idle(2);
    push(16'h1234);
    wait_done(1, 400);
    idle(3);
`endif

    done = 1'b1;
  end

endmodule
